sync_fifo_ctrl: RTL and testbench
=================================

Name: sync_fifo_ctrl

Overview:
Synchronous single-clock FIFO that wraps the storage array, read/write pointers and occupancy counter into one buffer.
- Turns producer/consumer enables into accepted write/read strobes.
- Drives those strobes as increment/decrement into an occupancy counter sub-module.
- Derives full/empty/almost flags from the returned count.
- Sits between a producer stage and a consumer stage in the data path.

Parameters:
WIDTH, 8, data word width in bits
DEPTH, 8, number of entries; power of two, >= 2
AW, $clog2(DEPTH), pointer width (derived, not overridden)
CW, $clog2(DEPTH)+1, occupancy count width; must represent 0..DEPTH (derived)
AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL
AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, synchronous, active-high
wr_en  input  1  producer requests write of wr_data this cycle
wr_data  input  WIDTH  write data
rd_en  input  1  consumer requests read this cycle
rd_data  output  WIDTH  registered read data
rd_valid  output  1  rd_data holds a newly read word (1-cycle pulse)
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_LEVEL
almost_empty  output  1  count <= AE_LEVEL
count  output  CW  current occupancy
overflow  output  1  sticky: write requested while full
underflow  output  1  sticky: read requested while empty

Behaviour:
- Reset (rst=1 at clk edge): wr_ptr=0, rd_ptr=0, count=0, rd_data=0, rd_valid=0, overflow=0, underflow=0. Storage array is not cleared.
- Flag values after reset: empty=1, full=0, almost_empty=1, almost_full=0.
- Reset has priority over all requests. Reset mid-operation discards all contents, and a request in the same cycle is ignored.
- wr_acc = wr_en & ~full; rd_acc = rd_en & ~empty. Both are computed from the registered flags of the current cycle.
- On wr_acc: mem[wr_ptr] <= wr_data; wr_ptr <= wr_ptr+1, wrapping modulo DEPTH through natural AW-bit rollover.
- On rd_acc: rd_data <= mem[rd_ptr]; rd_ptr <= rd_ptr+1 (wraps); rd_valid <= 1 next cycle.
- Read latency: 1 cycle from rd_acc edge to rd_data/rd_valid.
- When rd_acc is not asserted, rd_valid=0 and rd_data holds its last value.
- Occupancy counter sub-module: inc=wr_acc, dec=rd_acc. Updates only when exactly one of inc/dec is set: count+1 on inc, count-1 on dec. Count is unchanged when both or neither are set.
- Simultaneous wr_en & rd_en:
  - Neither full nor empty: both accepted, count unchanged, pointers both advance.
  - At full: only the read is accepted, the write is dropped, overflow sets, count becomes DEPTH-1.
  - At empty: only the write is accepted, the read is dropped, underflow sets, count becomes 1, rd_valid stays 0.
- Write-to-read latency: a word written at edge N is readable from edge N+1. An empty FIFO does not fall through.
- Flags are combinational compares of the registered count; no extra latency beyond count.
- overflow/underflow stay set until rst.
- count never exceeds DEPTH or goes below 0; the count width CW guarantees DEPTH is representable.

Decomposition:
- Shared package fifo_pkg holds:
  - default WIDTH/DEPTH localparams;
  - helper function computing AW/CW from DEPTH;
  - AF/AE default-offset constants.
- One natural sub-module: fifo_occ_counter (inputs inc, dec, rst, clk; output count[CW-1:0]). It is CW-wide and parameterised by CW.
- Storage array and pointers stay in the top module.

Test Plan:
- Reset then idle, DEPTH=8 WIDTH=8 -> count=0, empty=1, full=0, almost_empty=1, rd_valid=0, overflow=0, underflow=0.
- Write 0x11..0x88 (8 writes), then 8 reads:
  - after the 8th write: full=1, count=8, almost_full=1 from count=6;
  - reads return 0x11..0x88 in order, each rd_valid one cycle after rd_en;
  - final state: empty=1, count=0.
- Fill to 8, assert wr_en=1 & rd_en=1 with wr_data=0x99 -> read returns 0x11, 0x99 not stored, overflow=1 sticky, count=7.
- At empty, wr_en=1 & rd_en=1 with 0xAB -> underflow=1, rd_valid=0 next cycle, count=1; a later read returns 0xAB.
- Steady half-full (count=4), 20 cycles of simultaneous wr/rd with an incrementing pattern:
  - count stays 4 throughout;
  - pointers wrap past 7->0;
  - data order is preserved.
- Write 5 words, assert rst for 1 cycle while wr_en=1 -> count=0, empty=1, overflow/underflow cleared; the next read request sets underflow and gives rd_valid=0.

Source files
------------

// File: rtl/sync_fifo_ctrl_pkg.sv
// Shared sizing defaults and helpers for the synchronous FIFO slice.
// No logic, so no latency.
// No handshake of its own; holds only constants and sizing functions.
package fifo_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_DEPTH  = 8;

    // almost_full sits this many entries below DEPTH by default
    localparam int AF_OFFSET  = 2;
    // almost_empty threshold by default
    localparam int AE_DEFAULT = 2;

    // Pointer width: DEPTH is a power of two, so pointers wrap on natural rollover
    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    // Count width needs one extra bit so that DEPTH itself is representable
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_ctrl_if.sv
// Producer/consumer bus of the synchronous FIFO, with status flags.
// Wires only; latency is defined by whichever module drives the slave side.
// Requests past full/empty are dropped by the FIFO and reported on overflow/underflow.
interface sync_fifo_ctrl_if #(
    parameter int WIDTH = fifo_pkg::DEF_WIDTH,
    parameter int DEPTH = fifo_pkg::DEF_DEPTH
);
    localparam int CW = fifo_pkg::count_width(DEPTH);

    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             rd_en;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    // Producer/consumer side
    modport master (
        output wr_en, wr_data, rd_en,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    // FIFO side
    modport slave (
        input  wr_en, wr_data, rd_en,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

endinterface

// File: rtl/sync_fifo_ctrl_occ_counter.sv
// Occupancy counter: +1 on inc alone, -1 on dec alone, hold on both or neither.
// Count updates on the clock edge after the strobe.
// No backpressure; the caller guarantees inc only below DEPTH and dec only above 0.
module fifo_occ_counter #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] count
);
    localparam logic [CW-1:0] ONE = CW'(1);

    // Up/down count with synchronous reset; simultaneous inc and dec cancel
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && !dec) begin
            count <= count + ONE;
        end else if (dec && !inc) begin
            count <= count - ONE;
        end
    end

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO: storage, wrapping pointers, occupancy count and status flags.
// Read data and rd_valid appear 1 cycle after an accepted read; a write is readable the next cycle.
// Writes when full and reads when empty are dropped and latched on sticky overflow/underflow.
module sync_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - AF_OFFSET,
    parameter int AE_LEVEL = AE_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    sync_fifo_ctrl_if.slave  bus
);
    localparam int AW = ptr_width(DEPTH);
    localparam int CW = count_width(DEPTH);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    occ;
    logic             wr_acc;
    logic             rd_acc;
    logic [WIDTH-1:0] rd_data_q;
    logic             rd_valid_q;
    logic             overflow_q;
    logic             underflow_q;

    // Accept strobes come from the current registered flags only
    assign wr_acc = bus.wr_en && !bus.full;
    assign rd_acc = bus.rd_en && !bus.empty;

    fifo_occ_counter #(
        .CW (CW)
    ) u_occ (
        .clk   (clk),
        .rst   (rst),
        .inc   (wr_acc),
        .dec   (rd_acc),
        .count (occ)
    );

    // Storage is not cleared on reset; a write in the reset cycle is ignored
    always_ff @(posedge clk) begin
        if (wr_acc && !rst) begin
            mem[wr_ptr] <= bus.wr_data;
        end
    end

    // Pointers, registered read port and sticky error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_acc;
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_acc) begin
                rd_data_q <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + PTR_ONE;
            end
            if (bus.wr_en && bus.full) begin
                overflow_q <= 1'b1;
            end
            if (bus.rd_en && bus.empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

    // Flags are plain compares of the registered count
    assign bus.count        = occ;
    assign bus.full         = (occ == DEPTH_C);
    assign bus.empty        = (occ == '0);
    assign bus.almost_full  = (occ >= AF_C);
    assign bus.almost_empty = (occ <= AE_C);
    assign bus.rd_data      = rd_data_q;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Self-checking bench for sync_fifo_ctrl (DEPTH=8, WIDTH=8).
// Table of directed vectors plus hand sequences for steady state and mid-run reset.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_sync_fifo_ctrl;

    logic clk;
    logic rst;

    sync_fifo_ctrl_if #(.WIDTH(8), .DEPTH(8)) bus ();

    sync_fifo_ctrl #(.WIDTH(8), .DEPTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       wr;
        logic       rd;
        logic [7:0] wd;
        logic [3:0] cnt;
        logic       full;
        logic       empty;
        logic       af;
        logic       ae;
        logic       rv;
        logic [7:0] rdat;
        logic       ovf;
        logic       unf;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic add(input logic r, input logic w, input logic rd, input logic [7:0] wd,
                       input logic [3:0] cnt, input logic f, input logic e, input logic af,
                       input logic ae, input logic rv, input logic [7:0] rdat,
                       input logic ov, input logic un);
        vec_t v;
        v.rst = r;  v.wr = w;   v.rd = rd;  v.wd = wd;
        v.cnt = cnt; v.full = f; v.empty = e; v.af = af; v.ae = ae;
        v.rv = rv;  v.rdat = rdat; v.ovf = ov; v.unf = un;
        vecs.push_back(v);
    endtask

    // Apply inputs, clock once, sample just after the edge
    task automatic step(input logic r, input logic w, input logic rd, input logic [7:0] wd);
        rst         = r;
        bus.wr_en   = w;
        bus.rd_en   = rd;
        bus.wr_data = wd;
        @(posedge clk);
        #1;
    endtask

    // Compare the full visible state against an expectation
    task automatic check(input string name, input logic [3:0] cnt, input logic f,
                         input logic e, input logic af, input logic ae, input logic rv,
                         input logic [7:0] rdat, input logic ov, input logic un);
        logic [18:0] got;
        logic [18:0] exp;
        got = {bus.count, bus.full, bus.empty, bus.almost_full, bus.almost_empty,
               bus.rd_valid, bus.rd_data, bus.overflow, bus.underflow};
        exp = {cnt, f, e, af, ae, rv, rdat, ov, un};
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got cnt=%0d full=%b empty=%b af=%b ae=%b rv=%b rd=%h ovf=%b unf=%b, expected cnt=%0d full=%b empty=%b af=%b ae=%b rv=%b rd=%h ovf=%b unf=%b",
                     name, bus.count, bus.full, bus.empty, bus.almost_full, bus.almost_empty,
                     bus.rd_valid, bus.rd_data, bus.overflow, bus.underflow,
                     cnt, f, e, af, ae, rv, rdat, ov, un);
        end
    endtask

    initial begin
        rst = 1'b1; bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.wr_data = 8'h00;

        //   rst wr rd wd     cnt full emp af ae rv rdat   ov un
        add(1, 0, 0, 8'h00, 0, 0, 1, 0, 1, 0, 8'h00, 0, 0);  // reset
        add(0, 0, 0, 8'h00, 0, 0, 1, 0, 1, 0, 8'h00, 0, 0);  // idle
        add(0, 1, 0, 8'h11, 1, 0, 0, 0, 1, 0, 8'h00, 0, 0);
        add(0, 1, 0, 8'h22, 2, 0, 0, 0, 1, 0, 8'h00, 0, 0);
        add(0, 1, 0, 8'h33, 3, 0, 0, 0, 0, 0, 8'h00, 0, 0);
        add(0, 1, 0, 8'h44, 4, 0, 0, 0, 0, 0, 8'h00, 0, 0);
        add(0, 1, 0, 8'h55, 5, 0, 0, 0, 0, 0, 8'h00, 0, 0);
        add(0, 1, 0, 8'h66, 6, 0, 0, 1, 0, 0, 8'h00, 0, 0);
        add(0, 1, 0, 8'h77, 7, 0, 0, 1, 0, 0, 8'h00, 0, 0);
        add(0, 1, 0, 8'h88, 8, 1, 0, 1, 0, 0, 8'h00, 0, 0);  // full
        add(0, 1, 1, 8'h99, 7, 0, 0, 1, 0, 1, 8'h11, 1, 0);  // wr+rd at full
        add(0, 0, 1, 8'h00, 6, 0, 0, 1, 0, 1, 8'h22, 1, 0);
        add(0, 0, 1, 8'h00, 5, 0, 0, 0, 0, 1, 8'h33, 1, 0);
        add(0, 0, 1, 8'h00, 4, 0, 0, 0, 0, 1, 8'h44, 1, 0);
        add(0, 0, 1, 8'h00, 3, 0, 0, 0, 0, 1, 8'h55, 1, 0);
        add(0, 0, 1, 8'h00, 2, 0, 0, 0, 1, 1, 8'h66, 1, 0);
        add(0, 0, 1, 8'h00, 1, 0, 0, 0, 1, 1, 8'h77, 1, 0);
        add(0, 0, 1, 8'h00, 0, 0, 1, 0, 1, 1, 8'h88, 1, 0);  // empty, 0x99 never stored
        add(0, 1, 1, 8'hAB, 1, 0, 0, 0, 1, 0, 8'h88, 1, 1);  // wr+rd at empty
        add(0, 0, 1, 8'h00, 0, 0, 1, 0, 1, 1, 8'hAB, 1, 1);
        add(0, 0, 0, 8'h00, 0, 0, 1, 0, 1, 0, 8'hAB, 1, 1);  // rd_data holds

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].wr, vecs[i].rd, vecs[i].wd);
            check($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].full, vecs[i].empty,
                  vecs[i].af, vecs[i].ae, vecs[i].rv, vecs[i].rdat, vecs[i].ovf, vecs[i].unf);
        end

        // Steady half-full: 20 simultaneous wr/rd cycles, pointers wrap several times
        step(1, 0, 0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 8'(8'hC0 + i));
        end
        check("half_full_fill", 4, 0, 0, 0, 0, 0, 8'h00, 0, 0);
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 1, 8'(8'hC4 + i));
            check($sformatf("steady%0d", i), 4, 0, 0, 0, 0, 1, 8'(8'hC0 + i), 0, 0);
        end

        // Mid-run reset with a write request in the same cycle
        step(1, 0, 0, 8'h00);
        step(0, 0, 1, 8'h00);
        check("unf_before_rst", 0, 0, 1, 0, 1, 0, 8'h00, 0, 1);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0, 8'(8'h50 + i));
        end
        check("five_written", 5, 0, 0, 0, 0, 0, 8'h00, 0, 1);
        step(1, 1, 0, 8'hEE);
        check("rst_with_wr", 0, 0, 1, 0, 1, 0, 8'h00, 0, 0);
        step(0, 0, 1, 8'h00);
        check("rd_after_rst", 0, 0, 1, 0, 1, 0, 8'h00, 0, 1);
        step(0, 0, 0, 8'h00);
        check("idle_after_rst", 0, 0, 1, 0, 1, 0, 8'h00, 0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
